// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file: byte-strobed RW registers, read-only status slots,
// SLVERR on out-of-range or read-only writes, flat register view plus per-register write pulses.

module axi4_lite_regfile_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module axi4_lite_regfile #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  localparam int ADDR_WIDTH = (DATA_WIDTH == 64) ? 64 : 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int SLOTS    = 2 ** IDX_W;
  localparam logic [IDX_W:0]   NREG   = (IDX_W+1)'(NUM_REGS);
  localparam logic [SLOTS-1:0] RO_EXT = SLOTS'(RO_MASK);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> (ADDR_LSB + IDX_W)) == '0) && ({1'b0, a[ADDR_LSB +: IDX_W]} < NREG);
  endfunction

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_got, w_got;

  logic                  aw_hs, w_hs, have_aw, have_w, commit, ar_hs;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [IDX_W-1:0]      widx, ridx;
  logic                  wok, rlegal;
  logic [NUM_REGS-1:0]   we;
  logic [SLOTS-1:0][DATA_WIDTH-1:0] rd_vals;

  // AW and W may arrive in either order; the later one commits using live bus values
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign have_aw = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;
  assign waddr   = aw_got ? awaddr_q : AWADDR;
  assign wdata   = w_got ? wdata_q : WDATA;
  assign wstrb   = w_got ? wstrb_q : WSTRB;
  assign widx    = waddr[ADDR_LSB +: IDX_W];
  assign wok     = legal(waddr) && !RO_EXT[widx];
  assign commit  = (wstate == W_IDLE) && have_aw && have_w;

  assign ar_hs   = ARVALID && ARREADY;
  assign ridx    = ARADDR[ADDR_LSB +: IDX_W];
  assign rlegal  = legal(ARADDR);

  for (genvar i = 0; i < SLOTS; i++) begin : g_reg
    if (i >= NUM_REGS) begin : g_pad
      assign rd_vals[i] = '0;
    end else if (RO_MASK[i]) begin : g_ro
      assign we[i] = 1'b0;
      assign rd_vals[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      assign we[i] = commit && wok && (widx == IDX_W'(i));
      axi4_lite_regfile_reg #(.DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_reg (
        .aclk(aclk), .areset(areset), .we(we[i]), .wdata(wdata), .wstrb(wstrb), .q(q)
      );
      assign rd_vals[i] = q;
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end
  end

  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: if (commit) wnext = W_RESP;
      W_RESP: if (BREADY) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE: if (ar_hs)  rnext = R_DATA;
      R_DATA: if (RREADY) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wnext;
      rstate <= rnext;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= we;
      if (wstate == W_IDLE) begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          awaddr_q <= AWADDR;
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= WDATA;
          wstrb_q <= WSTRB;
        end
        // READY held low from a channel's handshake until the B handshake
        AWREADY <= !have_aw;
        WREADY  <= !have_w;
        if (commit) begin
          BVALID <= 1'b1;
          BRESP  <= wok ? OKAY : SLVERR;
        end
      end else if (BREADY) begin
        BVALID  <= 1'b0;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        AWREADY <= 1'b1;
        WREADY  <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= OKAY;
    end else if (rstate == R_IDLE) begin
      if (ar_hs) begin
        ARREADY <= 1'b0;
        RVALID  <= 1'b1;
        RDATA   <= rlegal ? rd_vals[ridx] : '0;
        RRESP   <= rlegal ? OKAY : SLVERR;
      end else begin
        ARREADY <= 1'b1;
      end
    end else if (RREADY) begin
      RVALID  <= 1'b0;
      ARREADY <= 1'b1;
    end
  end

  logic unused;
  assign unused = ^{AWPROT, ARPROT, reg_in};
endmodule
